// File: rtl/conv2_ctrl.sv
// conv2_ctrl: address/strobe sequencer for the Convolution 2 layer.
//
// For every output pixel of every output channel it runs one CLEAR cycle, K*K read cycles,
// READ_LAT drain cycles and one WRITE cycle, producing the input/weight read addresses,
// the MAC clear/enable strobes and the output write strobe/address.
//
// Ports:
//   clk_i      clock, rising edge
//   rst_ni     asynchronous active-low reset; aborts any run
//   start_i    run request, only honoured while idle
//   busy_o     high from the cycle after start is accepted until done
//   done_o     one-cycle pulse after the final output write
//   rd_en_o    input RAM / weight ROM read strobe
//   in_addr_o  input address  (oy+kr)*IN_W + (ox+kc)
//   w_addr_o   weight address ch*K*K + kr*K + kc
//   mac_clr_o  accumulator clear
//   mac_en_o   accumulate; rd_en_o delayed by READ_LAT
//   wr_en_o    output RAM write strobe
//   wr_addr_o  output address oy*OUT_W + ox
//   wr_ch_o    output channel of the current write
//
// Constraints on parameters: OUT_W == IN_W-K+1, 1 <= READ_LAT <= 4.

module conv2_ctrl #(
  parameter int unsigned IN_W     = 12,
  parameter int unsigned K        = 5,
  parameter int unsigned OUT_W    = 8,
  parameter int unsigned N_CH     = 3,
  parameter int unsigned READ_LAT = 1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       rd_en_o,
  output logic [7:0] in_addr_o,
  output logic [6:0] w_addr_o,
  output logic       mac_clr_o,
  output logic       mac_en_o,
  output logic       wr_en_o,
  output logic [5:0] wr_addr_o,
  output logic [1:0] wr_ch_o
);

  localparam int unsigned KW = (K > 1) ? $clog2(K) : 1;
  localparam int unsigned OW = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int unsigned CW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned LW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  localparam logic [KW-1:0] KMax   = KW'(K - 1);
  localparam logic [OW-1:0] OMax   = OW'(OUT_W - 1);
  localparam logic [CW-1:0] ChMax  = CW'(N_CH - 1);
  localparam logic [LW-1:0] LatMax = LW'(READ_LAT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StAccum,
    StDrain,
    StWrite,
    StFinish
  } state_e;

  state_e state_q, state_d;

  logic [KW-1:0] kc_q, kc_d, kr_q, kr_d;
  logic [OW-1:0] ox_q, ox_d, oy_q, oy_d;
  logic [CW-1:0] ch_q, ch_d;
  logic [LW-1:0] lat_q, lat_d;

  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       rd_en_q, rd_en_d;
  logic       mac_clr_q, mac_clr_d;
  logic       wr_en_q, wr_en_d;
  logic [7:0] in_addr_q, in_addr_d;
  logic [6:0] w_addr_q, w_addr_d;
  logic [5:0] wr_addr_q, wr_addr_d;
  logic [1:0] wr_ch_q, wr_ch_d;

  logic [READ_LAT-1:0] rd_pipe_q;

  // State and loop counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      kc_q    <= '0;
      kr_q    <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
      ch_q    <= '0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      kc_q    <= kc_d;
      kr_q    <= kr_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      ch_q    <= ch_d;
      lat_q   <= lat_d;
    end
  end

  // Next state and counter advance. Nesting from innermost: kc, kr, ox, oy, ch.
  always_comb begin
    state_d = state_q;
    kc_d    = kc_q;
    kr_d    = kr_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    ch_d    = ch_q;
    lat_d   = lat_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) state_d = StClear;
      end
      StClear: begin
        state_d = StAccum;
      end
      StAccum: begin
        if (kc_q == KMax) begin
          kc_d = '0;
          if (kr_q == KMax) begin
            kr_d    = '0;
            state_d = StDrain;
          end else begin
            kr_d = kr_q + 1'b1;
          end
        end else begin
          kc_d = kc_q + 1'b1;
        end
      end
      StDrain: begin
        if (lat_q == LatMax) begin
          lat_d   = '0;
          state_d = StWrite;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      StWrite: begin
        if (ox_q == OMax) begin
          ox_d = '0;
          if (oy_q == OMax) begin
            oy_d = '0;
            ch_d = (ch_q == ChMax) ? '0 : ch_q + 1'b1;
          end else begin
            oy_d = oy_q + 1'b1;
          end
        end else begin
          ox_d = ox_q + 1'b1;
        end
        if (ch_q == ChMax && oy_q == OMax && ox_q == OMax) begin
          state_d = StFinish;
        end else begin
          state_d = StClear;
        end
      end
      StFinish: begin
        kc_d    = '0;
        kr_d    = '0;
        ox_d    = '0;
        oy_d    = '0;
        ch_d    = '0;
        lat_d   = '0;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs are registered, so they are decoded from the next state and next counters;
  // this way each output register lines up with the state register in the same cycle.
  always_comb begin
    int unsigned row;
    int unsigned col;
    row       = 32'(oy_d) + 32'(kr_d);
    col       = 32'(ox_d) + 32'(kc_d);
    busy_d    = (state_d == StClear) || (state_d == StAccum) ||
                (state_d == StDrain) || (state_d == StWrite);
    done_d    = (state_d == StFinish);
    mac_clr_d = (state_d == StClear);
    rd_en_d   = (state_d == StAccum);
    wr_en_d   = (state_d == StWrite);
    // Addresses hold their last value while their strobe is low.
    in_addr_d = in_addr_q;
    w_addr_d  = w_addr_q;
    wr_addr_d = wr_addr_q;
    wr_ch_d   = wr_ch_q;
    if (rd_en_d) begin
      in_addr_d = 8'(row * IN_W + col);
      w_addr_d  = 7'(32'(ch_d) * K * K + 32'(kr_d) * K + 32'(kc_d));
    end
    if (wr_en_d) begin
      wr_addr_d = 6'(32'(oy_d) * OUT_W + 32'(ox_d));
      wr_ch_d   = 2'(ch_d);
    end
  end

  // Output registers and the mac_en delay line.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      mac_clr_q <= 1'b0;
      wr_en_q   <= 1'b0;
      in_addr_q <= '0;
      w_addr_q  <= '0;
      wr_addr_q <= '0;
      wr_ch_q   <= '0;
      rd_pipe_q <= '0;
    end else begin
      busy_q       <= busy_d;
      done_q       <= done_d;
      rd_en_q      <= rd_en_d;
      mac_clr_q    <= mac_clr_d;
      wr_en_q      <= wr_en_d;
      in_addr_q    <= in_addr_d;
      w_addr_q     <= w_addr_d;
      wr_addr_q    <= wr_addr_d;
      wr_ch_q      <= wr_ch_d;
      rd_pipe_q[0] <= rd_en_q;
      for (int i = 1; i < int'(READ_LAT); i++) begin
        rd_pipe_q[i] <= rd_pipe_q[i-1];
      end
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign rd_en_o   = rd_en_q;
  assign in_addr_o = in_addr_q;
  assign w_addr_o  = w_addr_q;
  assign mac_clr_o = mac_clr_q;
  assign mac_en_o  = rd_pipe_q[READ_LAT-1];
  assign wr_en_o   = wr_en_q;
  assign wr_addr_o = wr_addr_q;
  assign wr_ch_o   = wr_ch_q;

endmodule

// File: tb/tb_conv2_ctrl.sv
// Testbench for conv2_ctrl: one instance at READ_LAT=1, one at READ_LAT=3, both checked
// cycle by cycle against a timing model derived from the per-pixel schedule.

module tb_conv2_ctrl;

  localparam int IN_W  = 12;
  localparam int K     = 5;
  localparam int OUT_W = 8;
  localparam int N_CH  = 3;
  localparam int NPIX  = OUT_W * OUT_W * N_CH;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       rd_en;
    logic       mac_clr;
    logic       mac_en;
    logic       wr_en;
    logic [7:0] in_addr;
    logic [6:0] w_addr;
    logic [5:0] wr_addr;
    logic [1:0] wr_ch;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start0 = 1'b0;
  logic start3 = 1'b0;

  logic       busy0, done0, rd0, clr0, men0, wr0;
  logic [7:0] ia0;
  logic [6:0] wa0;
  logic [5:0] wra0;
  logic [1:0] wch0;
  logic       busy3, done3, rd3, clr3, men3, wr3;
  logic [7:0] ia3;
  logic [6:0] wa3;
  logic [5:0] wra3;
  logic [1:0] wch3;

  obs_t obs0, obs3;
  assign obs0 = {busy0, done0, rd0, clr0, men0, wr0, ia0, wa0, wra0, wch0};
  assign obs3 = {busy3, done3, rd3, clr3, men3, wr3, ia3, wa3, wra3, wch3};

  int errors = 0;
  int checks = 0;
  int shown  = 0;

  always #5 clk = ~clk;

  conv2_ctrl #(.READ_LAT(1)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start0),
    .busy_o(busy0), .done_o(done0), .rd_en_o(rd0), .in_addr_o(ia0), .w_addr_o(wa0),
    .mac_clr_o(clr0), .mac_en_o(men0), .wr_en_o(wr0), .wr_addr_o(wra0), .wr_ch_o(wch0)
  );

  conv2_ctrl #(.READ_LAT(3)) dut3 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start3),
    .busy_o(busy3), .done_o(done3), .rd_en_o(rd3), .in_addr_o(ia3), .w_addr_o(wa3),
    .mac_clr_o(clr3), .mac_en_o(men3), .wr_en_o(wr3), .wr_addr_o(wra3), .wr_ch_o(wch3)
  );

  // Expected outputs in cycle t after the start-accept edge (t=1 is the CLEAR cycle).
  // Each pixel takes 1 + K*K + lat + 1 cycles: clear, K*K taps, drain, write.
  function automatic obs_t model(input int t, input int lat);
    obs_t o;
    int per, p, off, ch, pix, tap;
    o   = '0;
    per = 1 + K * K + lat + 1;
    if (t >= 1 && t <= NPIX * per) begin
      p   = (t - 1) / per;
      off = (t - 1) % per;
      ch  = p / (OUT_W * OUT_W);
      pix = p % (OUT_W * OUT_W);
      o.busy    = 1'b1;
      o.mac_clr = (off == 0);
      if (off >= 1 && off <= K * K) begin
        tap       = off - 1;
        o.rd_en   = 1'b1;
        o.in_addr = 8'((pix / OUT_W + tap / K) * IN_W + pix % OUT_W + tap % K);
        o.w_addr  = 7'(ch * K * K + tap);
      end
      o.mac_en = (off >= 1 + lat) && (off <= K * K + lat);
      if (off == per - 1) begin
        o.wr_en   = 1'b1;
        o.wr_addr = 6'(pix);
        o.wr_ch   = 2'(ch);
      end
    end else if (t == NPIX * per + 1) begin
      o.done = 1'b1;
    end
    return o;
  endfunction

  // Addresses are only meaningful while their strobe is expected high.
  function automatic obs_t care_mask(input obs_t e);
    obs_t m;
    m = '1;
    if (!e.rd_en) begin
      m.in_addr = '0;
      m.w_addr  = '0;
    end
    if (!e.wr_en) begin
      m.wr_addr = '0;
      m.wr_ch   = '0;
    end
    return m;
  endfunction

  task automatic pulse_reset();
    rst_n  = 1'b0;
    start0 = 1'b0;
    start3 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (obs0 !== '0) begin
      errors++;
      $display("FAIL reset_hold0 got %h want 0", obs0);
    end
    checks++;
    if (obs3 !== '0) begin
      errors++;
      $display("FAIL reset_hold3 got %h want 0", obs3);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (obs0 !== '0 || obs3 !== '0) begin
        errors++;
        $display("FAIL idle_after_reset cyc %0d got %h/%h want 0", i, obs0, obs3);
      end
    end
  endtask

  task automatic test_first_pixel();
    int i;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    for (int t = 1; t <= 29; t++) begin
      // Hand-written first-pixel schedule: clear at 1, taps 2..26, mac_en 3..27, write 28.
      checks++;
      if (rd0 !== (t >= 2 && t <= 26) || men0 !== (t >= 3 && t <= 27) ||
          clr0 !== (t == 1 || t == 29) || wr0 !== (t == 28) || busy0 !== 1'b1) begin
        errors++;
        $display("FAIL first_pixel_strobes cyc %0d got rd=%b men=%b clr=%b wr=%b busy=%b",
                 t, rd0, men0, clr0, wr0, busy0);
      end
      if (t >= 2 && t <= 26) begin
        i = t - 2;
        checks++;
        if (ia0 !== 8'((i / 5) * 12 + i % 5) || wa0 !== 7'(i)) begin
          errors++;
          $display("FAIL first_pixel_addr cyc %0d got in=%0d w=%0d want in=%0d w=%0d",
                   t, ia0, wa0, (i / 5) * 12 + i % 5, i);
        end
      end
      if (t == 28) begin
        checks++;
        if (wra0 !== 6'd0 || wch0 !== 2'd0) begin
          errors++;
          $display("FAIL first_pixel_write got addr=%0d ch=%0d want 0/0", wra0, wch0);
        end
      end
      @(negedge clk);
    end
    pulse_reset();
  endtask

  // Full runs of both instances side by side. With noise set, start toggles randomly while
  // each instance is busy; it must have no effect on either schedule.
  task automatic test_full_run(input bit noise);
    obs_t e0, e3, m0, m3;
    int total0, total3;
    int wr_cnt0, wr_cnt3, done_cnt0, done_t0, done_t3;
    int first_ch1_w, last_in, last_w;
    total0 = NPIX * (K * K + 3) + 1;
    total3 = NPIX * (K * K + 5) + 1;
    wr_cnt0 = 0; wr_cnt3 = 0; done_cnt0 = 0; done_t0 = -1; done_t3 = -1;
    first_ch1_w = -1; last_in = -1; last_w = -1;
    start0 = 1'b1;
    start3 = 1'b1;
    @(negedge clk);
    for (int t = 1; t <= total3 + 3; t++) begin
      start0 = noise && (t <= total0) ? 1'($urandom_range(1)) : 1'b0;
      start3 = noise && (t <= total3) ? 1'($urandom_range(1)) : 1'b0;
      e0 = model(t, 1);
      e3 = model(t, 3);
      m0 = care_mask(e0);
      m3 = care_mask(e3);
      checks++;
      if ($isunknown(obs0) || ((obs0 & m0) !== (e0 & m0))) begin
        errors++;
        if (shown < 20) $display("FAIL run_lat1 cyc %0d got %h want %h", t, obs0, e0);
        shown++;
      end
      checks++;
      if ($isunknown(obs3) || ((obs3 & m3) !== (e3 & m3))) begin
        errors++;
        if (shown < 20) $display("FAIL run_lat3 cyc %0d got %h want %h", t, obs3, e3);
        shown++;
      end
      if (wr0 === 1'b1) wr_cnt0++;
      if (wr3 === 1'b1) wr_cnt3++;
      if (done0 === 1'b1) begin
        done_cnt0++;
        done_t0 = t;
      end
      if (done3 === 1'b1) done_t3 = t;
      if (rd0 === 1'b1) begin
        if (wr_cnt0 == OUT_W * OUT_W && first_ch1_w < 0) first_ch1_w = int'(wa0);
        last_in = int'(ia0);
        last_w  = int'(wa0);
      end
      @(negedge clk);
    end
    checks++;
    if (wr_cnt0 != 192 || wr_cnt3 != 192) begin
      errors++;
      $display("FAIL write_count got %0d/%0d want 192/192", wr_cnt0, wr_cnt3);
    end
    checks++;
    if (done_cnt0 != 1 || done_t0 != 5377) begin
      errors++;
      $display("FAIL done_lat1 got count=%0d cyc=%0d want 1 at 5377", done_cnt0, done_t0);
    end
    checks++;
    if (done_t3 != 5761) begin
      errors++;
      $display("FAIL done_lat3 got cyc=%0d want 5761", done_t3);
    end
    checks++;
    if (first_ch1_w != 25) begin
      errors++;
      $display("FAIL first_ch1_w_addr got %0d want 25", first_ch1_w);
    end
    checks++;
    if (last_in != 143 || last_w != 74) begin
      errors++;
      $display("FAIL last_pixel_addr got in=%0d w=%0d want 143/74", last_in, last_w);
    end
  endtask

  task automatic test_reset_midrun();
    obs_t e0, m0;
    int stop;
    stop = (OUT_W * OUT_W + 20) * (K * K + 3) + 10;  // ch=1, pixel 20, mid-accumulate
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    for (int t = 1; t <= stop; t++) begin
      e0 = model(t, 1);
      m0 = care_mask(e0);
      if (t == stop) begin
        checks++;
        if ($isunknown(obs0) || ((obs0 & m0) !== (e0 & m0))) begin
          errors++;
          $display("FAIL pre_abort cyc %0d got %h want %h", t, obs0, e0);
        end
      end
      if (t < stop) @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs0 !== '0) begin
      errors++;
      $display("FAIL abort_immediate got %h want 0", obs0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      checks++;
      if (wr0 !== 1'b0 || done0 !== 1'b0 || busy0 !== 1'b0 || men0 !== 1'b0) begin
        errors++;
        $display("FAIL post_abort_quiet cyc %0d got wr=%b done=%b busy=%b men=%b",
                 i, wr0, done0, busy0, men0);
      end
    end
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    for (int t = 1; t <= 30; t++) begin
      e0 = model(t, 1);
      m0 = care_mask(e0);
      checks++;
      if ($isunknown(obs0) || ((obs0 & m0) !== (e0 & m0))) begin
        errors++;
        $display("FAIL restart cyc %0d got %h want %h", t, obs0, e0);
      end
      @(negedge clk);
    end
    pulse_reset();
  endtask

  initial begin
    test_reset();
    test_first_pixel();
    test_full_run(1'b0);
    test_full_run(1'b1);
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
